// File: rtl/cordic_gain_comp.sv
// Pipelined multi-channel CORDIC gain compensator.
// Scales each signed channel by K(n) or 1/K(n), with round-half-up and saturation,
// behind a valid/ready stream interface with a two-stage stallable pipeline.
module cordic_gain_comp #(
  parameter int unsigned DSIZE  = 16,
  parameter int unsigned CH     = 2,
  parameter int unsigned MAXSEL = 16
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*DSIZE-1:0]   in_data,
  input  logic [4:0]            sel,
  input  logic                  en,
  input  logic                  inv,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*DSIZE-1:0]   out_data,
  output logic [CH-1:0]         out_sat
);

  localparam int unsigned CW  = DSIZE + 2;
  localparam int unsigned PW  = 2 * DSIZE + 3;
  localparam int unsigned LIM = (MAXSEL > 16) ? 16 : MAXSEL;
  localparam real SCALE = 2.0 ** DSIZE;

  localparam real K0  = 0.7071067811865476;
  localparam real K1  = 0.6324555320336759;
  localparam real K2  = 0.6135719910778963;
  localparam real K3  = 0.6088339125177524;
  localparam real K4  = 0.6076482562561683;
  localparam real K5  = 0.6073517701412960;
  localparam real K6  = 0.6072776440935261;
  localparam real K7  = 0.6072591122988928;
  localparam real K8  = 0.6072544793325625;
  localparam real K9  = 0.6072533210898753;
  localparam real K10 = 0.6072530315291345;
  localparam real K11 = 0.6072529591389450;
  localparam real K12 = 0.6072529410413973;
  localparam real K13 = 0.6072529365170104;
  localparam real K14 = 0.6072529353859135;
  localparam real K15 = 0.6072529351031394;
  localparam real K16 = 0.6072529350324458;

  // Gain coefficients, unsigned Q2.DSIZE, rounded to nearest
  localparam logic [CW-1:0] KTAB [17] = '{
    CW'($rtoi(K0 * SCALE + 0.5)),  CW'($rtoi(K1 * SCALE + 0.5)),
    CW'($rtoi(K2 * SCALE + 0.5)),  CW'($rtoi(K3 * SCALE + 0.5)),
    CW'($rtoi(K4 * SCALE + 0.5)),  CW'($rtoi(K5 * SCALE + 0.5)),
    CW'($rtoi(K6 * SCALE + 0.5)),  CW'($rtoi(K7 * SCALE + 0.5)),
    CW'($rtoi(K8 * SCALE + 0.5)),  CW'($rtoi(K9 * SCALE + 0.5)),
    CW'($rtoi(K10 * SCALE + 0.5)), CW'($rtoi(K11 * SCALE + 0.5)),
    CW'($rtoi(K12 * SCALE + 0.5)), CW'($rtoi(K13 * SCALE + 0.5)),
    CW'($rtoi(K14 * SCALE + 0.5)), CW'($rtoi(K15 * SCALE + 0.5)),
    CW'($rtoi(K16 * SCALE + 0.5))
  };

  // Inverse-gain coefficients for input pre-scaling
  localparam logic [CW-1:0] ITAB [17] = '{
    CW'($rtoi(SCALE / K0 + 0.5)),  CW'($rtoi(SCALE / K1 + 0.5)),
    CW'($rtoi(SCALE / K2 + 0.5)),  CW'($rtoi(SCALE / K3 + 0.5)),
    CW'($rtoi(SCALE / K4 + 0.5)),  CW'($rtoi(SCALE / K5 + 0.5)),
    CW'($rtoi(SCALE / K6 + 0.5)),  CW'($rtoi(SCALE / K7 + 0.5)),
    CW'($rtoi(SCALE / K8 + 0.5)),  CW'($rtoi(SCALE / K9 + 0.5)),
    CW'($rtoi(SCALE / K10 + 0.5)), CW'($rtoi(SCALE / K11 + 0.5)),
    CW'($rtoi(SCALE / K12 + 0.5)), CW'($rtoi(SCALE / K13 + 0.5)),
    CW'($rtoi(SCALE / K14 + 0.5)), CW'($rtoi(SCALE / K15 + 0.5)),
    CW'($rtoi(SCALE / K16 + 0.5))
  };

  localparam logic [CW-1:0]        ONE  = {2'b01, DSIZE'(0)};
  localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (DSIZE - 1));
  localparam logic signed [PW-1:0] MAXP = PW'((64'd1 << (DSIZE - 1)) - 64'd1);
  localparam logic signed [PW-1:0] MINN = ~MAXP;

  logic                  advance;
  logic [4:0]            nc;
  logic [CW-1:0]         coef;
  logic signed [PW-1:0]  prod [CH];
  logic signed [PW-1:0]  p1 [CH];
  logic                  v1;
  logic signed [PW-1:0]  rnd [CH];
  logic [CH*DSIZE-1:0]   sat_data;
  logic [CH-1:0]         sat_flag;

  // The whole pipeline moves only when the output slot is free or being drained
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 1: clamp iteration index, select coefficient, multiply each channel
  always_comb begin
    nc   = (sel > 5'(LIM)) ? 5'(LIM) : sel;
    coef = inv ? ITAB[nc] : KTAB[nc];
    if (!en) coef = ONE;
    for (int i = 0; i < CH; i++) begin
      prod[i] = PW'($signed(in_data[i*DSIZE +: DSIZE])) * $signed(PW'({1'b0, coef}));
    end
  end

  // Stage 2: round half up, drop fraction bits, saturate to DSIZE
  always_comb begin
    sat_data = '0;
    sat_flag = '0;
    for (int i = 0; i < CH; i++) begin
      rnd[i] = (p1[i] + HALF) >>> DSIZE;
      if (rnd[i] > MAXP) begin
        sat_data[i*DSIZE +: DSIZE] = DSIZE'(MAXP);
        sat_flag[i]                = 1'b1;
      end else if (rnd[i] < MINN) begin
        sat_data[i*DSIZE +: DSIZE] = DSIZE'(MINN);
        sat_flag[i]                = 1'b1;
      end else begin
        sat_data[i*DSIZE +: DSIZE] = DSIZE'(rnd[i]);
      end
    end
  end

  // Pipeline registers; everything holds while the output is stalled
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
      for (int i = 0; i < CH; i++) p1[i] <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      out_valid <= v1;
      out_data  <= sat_data;
      out_sat   <= sat_flag;
      for (int i = 0; i < CH; i++) p1[i] <= prod[i];
    end
  end

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Directed bench for cordic_gain_comp: vector table plus stall/stream and reset sequences.
module tb_cordic_gain_comp;

  localparam int unsigned DSIZE = 16;
  localparam int unsigned CH    = 2;

  logic                 clock = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH*DSIZE-1:0]  in_data;
  logic [4:0]           sel;
  logic                 en;
  logic                 inv;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH*DSIZE-1:0]  out_data;
  logic [CH-1:0]        out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_gain_comp #(.DSIZE(DSIZE), .CH(CH), .MAXSEL(16)) dut (
    .clock(clock), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sel(sel), .en(en), .inv(inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic [4:0]  s;
    logic        e;
    logic        iv;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  es;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] stream_word(input int i);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(16'h0100 * (i + 1) + 16'h0011);
    b = 16'(16'hA000 + i);
    return {b, a};
  endfunction

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        held;
    logic [31:0] held_data;
    int          idx;
    int          oidx;

    // d0, d1, sel, en, inv, exp0, exp1, exp_sat
    vecs[0]  = '{16'h4000, 16'hC000, 5'd0,  1'b1, 1'b0, 16'h2D41, 16'hD2BF, 2'b00};
    vecs[1]  = '{16'h7FFF, 16'h8000, 5'd7,  1'b0, 1'b1, 16'h7FFF, 16'h8000, 2'b00};
    vecs[2]  = '{16'h7FFF, 16'h8000, 5'd16, 1'b0, 1'b0, 16'h7FFF, 16'h8000, 2'b00};
    vecs[3]  = '{16'h7000, 16'h9000, 5'd16, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 2'b11};
    vecs[4]  = '{16'h1000, 16'h0000, 5'd16, 1'b1, 1'b1, 16'h1A59, 16'h0000, 2'b00};
    vecs[5]  = '{16'h1000, 16'h0000, 5'd25, 1'b1, 1'b1, 16'h1A59, 16'h0000, 2'b00};
    vecs[6]  = '{16'h7000, 16'h9000, 5'd31, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 2'b11};
    vecs[7]  = '{16'h4000, 16'hC000, 5'd1,  1'b1, 1'b0, 16'h287A, 16'hD786, 2'b00};
    vecs[8]  = '{16'h4000, 16'hC000, 5'd0,  1'b1, 1'b1, 16'h5A83, 16'hA57E, 2'b00};
    vecs[9]  = '{16'h7FFF, 16'h8000, 5'd16, 1'b1, 1'b0, 16'h4DBA, 16'hB246, 2'b00};
    vecs[10] = '{16'h1234, 16'hFEDC, 5'd3,  1'b0, 1'b1, 16'h1234, 16'hFEDC, 2'b00};
    vecs[11] = '{16'h7FFF, 16'h8000, 5'd20, 1'b1, 1'b0, 16'h4DBA, 16'hB246, 2'b00};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; en = 1'b0; inv = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data",  64'(out_data),  64'd0);
    chk("reset out_sat",   64'(out_sat),   64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    step();

    // Single-sample vectors: check the two-cycle latency and the result
    for (int v = 0; v < 12; v++) begin
      in_data = {vecs[v].d1, vecs[v].d0};
      sel = vecs[v].s; en = vecs[v].e; inv = vecs[v].iv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d latency1 out_valid", v), 64'(out_valid), 64'd0);
      step();
      chk($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d out_data", v), 64'(out_data), 64'({vecs[v].e1, vecs[v].e0}));
      chk($sformatf("vec%0d out_sat", v), 64'(out_sat), 64'(vecs[v].es));
      step();
      chk($sformatf("vec%0d bubble out_valid", v), 64'(out_valid), 64'd0);
    end

    // Stream of 8 pass-through samples with out_ready cycling 1,0,0
    en = 1'b0; inv = 1'b0; sel = 5'd0;
    idx = 0; oidx = 0; held = 1'b0; held_data = '0;
    for (int cyc = 0; cyc < 80 && oidx < 8; cyc++) begin
      in_valid  = (idx < 8);
      in_data   = stream_word(idx);
      out_ready = ((cyc % 3) == 0);
      #2;
      chk($sformatf("stream c%0d in_ready", cyc), 64'(in_ready),
          64'(!(out_valid && !out_ready)));
      if (held) begin
        chk($sformatf("stream c%0d held valid", cyc), 64'(out_valid), 64'd1);
        chk($sformatf("stream c%0d held data", cyc), 64'(out_data), 64'(held_data));
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream out%0d data", oidx), 64'(out_data), 64'(stream_word(oidx)));
        oidx++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) idx++;
      step();
    end
    chk("stream outputs received", 64'(oidx), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stream drain%0d out_valid", k), 64'(out_valid), 64'd0);
    end

    // Reset with two samples in flight
    in_data = stream_word(3); in_valid = 1'b1;
    step();
    in_data = stream_word(4);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset out_valid", 64'(out_valid), 64'd0);
    chk("midreset out_data",  64'(out_data),  64'd0);
    chk("midreset in_ready",  64'(in_ready),  64'd1);
    step();
    rst = 1'b0;
    step();
    chk("postreset flushed", 64'(out_valid), 64'd0);
    in_data = {16'hC000, 16'h4000}; sel = 5'd0; en = 1'b1; inv = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("postreset latency1", 64'(out_valid), 64'd0);
    step();
    chk("postreset out_valid", 64'(out_valid), 64'd1);
    chk("postreset out_data",  64'(out_data),  64'({16'hD2BF, 16'h2D41}));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
